// File: rtl/mult_dispatch_pkg.sv
// Shared widths and FSM encoding for the mult_dispatch sequencer in front of
// the sequential Booth multiply core.
package mult_dispatch_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 17;
  localparam int PAIR_W = 2 * OP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_dispatch_fifo.sv
// Synchronous operand-pair FIFO (DEPTH x WIDTH) with full/empty flags and a
// combinational read port showing the oldest entry.
module mult_dispatch_fifo
  import mult_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PAIR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + ptr_t'(1);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering in the simulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mult_dispatch.sv
// Drives the multiply core's reset/load/start/rdy protocol from a buffered
// operand stream and returns products on a valid/ready stream.
// Optional RUN timeout with sticky err: define MULT_DISPATCH_TIMEOUT_EN.
module mult_dispatch
  import mult_dispatch_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LOAD_CYC = 2
`ifdef MULT_DISPATCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              m_rst,
  output logic              m_start,
  output logic [OP_W-1:0]   m_inp1,
  output logic [OP_W-1:0]   m_inp2,
  input  logic [PROD_W-1:0] m_prod,
  input  logic              m_rdy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              err
);

  localparam int LCW = $clog2(LOAD_CYC + 1);

  state_e              state_q, state_d;
  logic [LCW-1:0]      load_cnt_q, load_cnt_d;
  logic [OP_W-1:0]     inp1_q, inp1_d, inp2_q, inp2_d;
  logic [PROD_W-1:0]   out_prod_q, out_prod_d;
  logic                m_rdy_q;
  logic                rdy_rise;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAIR_W-1:0]   fifo_dout;

`ifdef MULT_DISPATCH_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] run_cnt_q, run_cnt_d;
  logic           err_q, err_d;
`endif

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  mult_dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A rdy already high when RUN begins has m_rdy_q set, so it never counts.
  assign rdy_rise = m_rdy && !m_rdy_q;

  assign m_inp1   = inp1_q;
  assign m_inp2   = inp2_q;
  assign out_prod = out_prod_q;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    inp1_d     = inp1_q;
    inp2_d     = inp2_q;
    out_prod_d = out_prod_q;
    fifo_pop   = 1'b0;
    m_rst      = 1'b1;
    m_start    = 1'b0;
    out_valid  = 1'b0;
`ifdef MULT_DISPATCH_TIMEOUT_EN
    run_cnt_d  = '0;
    err_d      = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          {inp1_d, inp2_d} = fifo_dout;
          load_cnt_d       = '0;
          state_d          = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_cnt_q == LCW'(LOAD_CYC - 1)) state_d = ST_RUN;
        else load_cnt_d = load_cnt_q + LCW'(1);
      end
      ST_RUN: begin
        m_rst   = 1'b0;
        m_start = 1'b1;
        if (rdy_rise) begin
          out_prod_d = m_prod;
          state_d    = ST_OUT;
        end
`ifdef MULT_DISPATCH_TIMEOUT_EN
        else if (run_cnt_q == TCW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          out_prod_d = '1;
          state_d    = ST_OUT;
        end else begin
          run_cnt_d = run_cnt_q + TCW'(1);
        end
`endif
      end
      ST_OUT: begin
        m_rst     = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      inp1_q     <= '0;
      inp2_q     <= '0;
      out_prod_q <= '0;
      m_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      inp1_q     <= inp1_d;
      inp2_q     <= inp2_d;
      out_prod_q <= out_prod_d;
      m_rdy_q    <= m_rdy;
    end
  end

`ifdef MULT_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
